// File: rtl/lit_branch_decoder.sv
// lit_branch_decoder: Q-phase sequencer and decoder for the literal and
// control-flow instruction groups of a PIC16F-style core.
//
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   instr_current     instruction register contents (14 bits)
//   hold              freezes the sequencer and masks all enables
//   q_count           current Q phase (0..3)
//   alu_sel_l, alu_op ALU operand select and operation
//   alu_status_wr_en  Z/C/DC write enable
//   w_reg_wr_en       W register write enable
//   instr_rd_en       instruction fetch from mem[PC]
//   incr_pc_en        PC increment
//   pc_load_en        PC load (literal target or stack top)
//   pc_src            0 = literal target, 1 = stack
//   stack_push_en     push current PC
//   stack_pop_en      pop stack
//   flush_active      current cycle is a forced NOP
//   illegal_instr     instr_current matches no supported encoding
module lit_branch_decoder #(
    parameter int ALU_OP_WIDTH = 4,
    parameter bit RESET_FLUSH  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [13:0]             instr_current,
    input  logic                    hold,
    output logic [1:0]              q_count,
    output logic                    alu_sel_l,
    output logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic                    alu_status_wr_en,
    output logic                    w_reg_wr_en,
    output logic                    instr_rd_en,
    output logic                    incr_pc_en,
    output logic                    pc_load_en,
    output logic                    pc_src,
    output logic                    stack_push_en,
    output logic                    stack_pop_en,
    output logic                    flush_active,
    output logic                    illegal_instr
);

    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_PASSLF = ALU_OP_WIDTH'(0);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD    = ALU_OP_WIDTH'(1);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB    = ALU_OP_WIDTH'(2);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND    = ALU_OP_WIDTH'(3);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_IOR    = ALU_OP_WIDTH'(4);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR    = ALU_OP_WIDTH'(5);

    logic [1:0] q;
    logic       flush;

    logic is_nop, is_ret, is_movlw, is_retlw, is_iorlw, is_andlw;
    logic is_xorlw, is_sublw, is_addlw, is_call, is_goto;
    logic exec, act, q1, q3, lit, arith, branch, pops, known;

    // Opcode field matches; the groups are mutually exclusive.
    always_comb begin
        is_nop   = (instr_current[13:7] == 7'd0) && (instr_current[4:0] == 5'd0);
        is_ret   = (instr_current == 14'h0008);
        is_movlw = (instr_current[13:10] == 4'b1100);
        is_retlw = (instr_current[13:10] == 4'b1101);
        is_iorlw = (instr_current[13:8] == 6'b111000);
        is_andlw = (instr_current[13:8] == 6'b111001);
        is_xorlw = (instr_current[13:8] == 6'b111010);
        is_sublw = (instr_current[13:9] == 5'b11110);
        is_addlw = (instr_current[13:9] == 5'b11111);
        is_call  = (instr_current[13:11] == 3'b100);
        is_goto  = (instr_current[13:11] == 3'b101);
    end

    always_comb begin
        // A flush cycle discards instr_current entirely.
        exec   = !flush;
        act    = !rst && !hold;
        q1     = (q == 2'd1);
        q3     = (q == 2'd3);
        arith  = exec && (is_iorlw || is_andlw || is_xorlw || is_sublw || is_addlw);
        lit    = arith || (exec && (is_movlw || is_retlw));
        pops   = exec && (is_ret || is_retlw);
        branch = pops || (exec && (is_call || is_goto));
        known  = is_nop || is_ret || is_movlw || is_retlw || is_iorlw
              || is_andlw || is_xorlw || is_sublw || is_addlw
              || is_call || is_goto;
    end

    always_comb begin
        alu_op = ALU_OP_PASSLF;
        if (exec) begin
            unique case (1'b1)
                is_addlw: alu_op = ALU_OP_ADD;
                is_sublw: alu_op = ALU_OP_SUB;
                is_andlw: alu_op = ALU_OP_AND;
                is_iorlw: alu_op = ALU_OP_IOR;
                is_xorlw: alu_op = ALU_OP_XOR;
                default:  alu_op = ALU_OP_PASSLF;
            endcase
        end
    end

    always_comb begin
        q_count          = q;
        flush_active     = flush;
        alu_sel_l        = act && q1 && lit;
        w_reg_wr_en      = act && q1 && lit;
        alu_status_wr_en = act && q1 && arith;
        instr_rd_en      = act && q3;
        pc_load_en       = act && q3 && branch;
        incr_pc_en       = act && q3 && !branch;
        pc_src           = pops;
        stack_push_en    = act && q3 && exec && is_call;
        stack_pop_en     = act && q3 && pops;
        illegal_instr    = exec && !known;
    end

    // The word fetched on a loading Q3 is stale, so the next cycle flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= 2'd0;
            flush <= RESET_FLUSH;
        end else if (!hold) begin
            q <= q + 2'd1;
            if (q3) begin
                flush <= pc_load_en;
            end
        end
    end

endmodule

// File: tb/tb_lit_branch_decoder.sv
// Self-checking bench for lit_branch_decoder: an instruction-class model
// compared every cycle, plus hand-computed directed expectations.
module tb_lit_branch_decoder;

    localparam logic [3:0] OP_PASSLF = 4'd0;
    localparam logic [3:0] OP_ADD    = 4'd1;
    localparam logic [3:0] OP_SUB    = 4'd2;
    localparam logic [3:0] OP_AND    = 4'd3;
    localparam logic [3:0] OP_IOR    = 4'd4;
    localparam logic [3:0] OP_XOR    = 4'd5;

    localparam int C_NOP = 0, C_RET = 1, C_MOV = 2, C_RETLW = 3;
    localparam int C_IOR = 4, C_AND = 5, C_XOR = 6, C_SUB = 7;
    localparam int C_ADD = 8, C_CALL = 9, C_GOTO = 10, C_ILL = 11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] instr = 14'h0000;
    logic        hold = 1'b0;
    logic [1:0]  q_count;
    logic        alu_sel_l;
    logic [3:0]  alu_op;
    logic        alu_status_wr_en, w_reg_wr_en, instr_rd_en, incr_pc_en;
    logic        pc_load_en, pc_src, stack_push_en, stack_pop_en;
    logic        flush_active, illegal_instr;

    int checks = 0;
    int errors = 0;
    int m_q = 0;
    bit m_fl = 1'b1;
    bit cmp_on = 1'b0;
    int wcount;

    lit_branch_decoder #(.ALU_OP_WIDTH(4), .RESET_FLUSH(1'b1)) dut (
        .clk(clk), .rst(rst), .instr_current(instr), .hold(hold),
        .q_count(q_count), .alu_sel_l(alu_sel_l), .alu_op(alu_op),
        .alu_status_wr_en(alu_status_wr_en), .w_reg_wr_en(w_reg_wr_en),
        .instr_rd_en(instr_rd_en), .incr_pc_en(incr_pc_en),
        .pc_load_en(pc_load_en), .pc_src(pc_src),
        .stack_push_en(stack_push_en), .stack_pop_en(stack_pop_en),
        .flush_active(flush_active), .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    function automatic int classify(input logic [13:0] i);
        casez (i)
            14'b00_0000_0??0_0000: return C_NOP;
            14'b00_0000_0000_1000: return C_RET;
            14'b11_00??_????_????: return C_MOV;
            14'b11_01??_????_????: return C_RETLW;
            14'b11_1000_????_????: return C_IOR;
            14'b11_1001_????_????: return C_AND;
            14'b11_1010_????_????: return C_XOR;
            14'b11_110?_????_????: return C_SUB;
            14'b11_111?_????_????: return C_ADD;
            14'b10_0???_????_????: return C_CALL;
            14'b10_1???_????_????: return C_GOTO;
            default:               return C_ILL;
        endcase
    endfunction

    function automatic logic [3:0] op_of(input int c);
        case (c)
            C_ADD:   return OP_ADD;
            C_SUB:   return OP_SUB;
            C_AND:   return OP_AND;
            C_IOR:   return OP_IOR;
            C_XOR:   return OP_XOR;
            default: return OP_PASSLF;
        endcase
    endfunction

    function automatic bit is_branch(input int c);
        return c == C_GOTO || c == C_CALL || c == C_RET || c == C_RETLW;
    endfunction

    task automatic cmp(input string n, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", n, $time, got, exp);
        end
    endtask

    // Instruction-cycle model: phase advances unless held; a branch that
    // executes (i.e. not in a flush slot) makes the following cycle a flush.
    always @(posedge clk) begin
        if (rst) begin
            m_q  = 0;
            m_fl = 1'b1;
        end else if (!hold) begin
            if (m_q == 3)
                m_fl = !m_fl && is_branch(classify(instr));
            m_q = (m_q + 1) % 4;
        end
    end

    always @(negedge clk) begin : compare
        int  c;
        bit  act, lit, arith, br, ret;
        if (cmp_on) begin
            c     = m_fl ? C_NOP : classify(instr);
            act   = !rst && !hold;
            arith = c inside {C_IOR, C_AND, C_XOR, C_SUB, C_ADD};
            lit   = arith || c == C_MOV || c == C_RETLW;
            br    = is_branch(c);
            ret   = c == C_RET || c == C_RETLW;
            cmp("q_count", q_count, m_q[7:0]);
            cmp("flush_active", flush_active, m_fl);
            cmp("alu_op", alu_op, op_of(c));
            cmp("alu_sel_l", alu_sel_l, act && m_q == 1 && lit);
            cmp("w_reg_wr_en", w_reg_wr_en, act && m_q == 1 && lit);
            cmp("status_wr_en", alu_status_wr_en, act && m_q == 1 && arith);
            cmp("instr_rd_en", instr_rd_en, act && m_q == 3);
            cmp("incr_pc_en", incr_pc_en, act && m_q == 3 && !br);
            cmp("pc_load_en", pc_load_en, act && m_q == 3 && br);
            cmp("pc_src", pc_src, ret);
            cmp("push", stack_push_en, act && m_q == 3 && c == C_CALL);
            cmp("pop", stack_pop_en, act && m_q == 3 && ret);
            cmp("illegal", illegal_instr, c == C_ILL);
        end
    end

    task automatic tick(input logic [13:0] i, input logic h, input logic r);
        @(posedge clk);
        #1;
        instr = i;
        hold  = h;
        rst   = r;
        #3;
        if (w_reg_wr_en) wcount++;
    endtask

    task automatic nop_cycle();
        for (int k = 0; k < 4; k++) tick(14'h0000, 1'b0, 1'b0);
    endtask

    initial begin
        tick(14'h0000, 1'b0, 1'b1);
        cmp_on = 1'b1;
        tick(14'h0000, 1'b0, 1'b1);
        cmp("rst_q", q_count, 0);
        cmp("rst_rd", instr_rd_en, 0);

        for (int k = 0; k < 4; k++) begin
            tick(14'h0000, 1'b0, 1'b0);
            if (k == 0) cmp("reset_flush", flush_active, 1);
            if (k == 3) cmp("flush_fetch", {instr_rd_en, incr_pc_en}, 2'b11);
        end
        for (int k = 0; k < 4; k++) begin
            tick(14'h0000, 1'b0, 1'b0);
            if (k == 0) cmp("nop_noflush", flush_active, 0);
        end

        for (int k = 0; k < 4; k++) begin
            tick(14'h3055, 1'b0, 1'b0);
            if (k == 1) begin
                cmp("movlw_sel", alu_sel_l, 1);
                cmp("movlw_op", alu_op, OP_PASSLF);
                cmp("movlw_w", w_reg_wr_en, 1);
                cmp("movlw_st", alu_status_wr_en, 0);
            end
        end
        for (int k = 0; k < 4; k++) begin
            tick(14'h3E01, 1'b0, 1'b0);
            if (k == 1) cmp("addlw_op_st", {alu_op, alu_status_wr_en}, {OP_ADD, 1'b1});
        end

        for (int k = 0; k < 4; k++) begin
            tick(14'h2805, 1'b0, 1'b0);
            if (k == 3) cmp("goto_q3", {pc_load_en, pc_src, incr_pc_en}, 3'b100);
        end
        wcount = 0;
        for (int k = 0; k < 4; k++) begin
            tick(14'h3055, 1'b0, 1'b0);
            if (k == 0) cmp("goto_flush", flush_active, 1);
        end
        cmp("flush_no_w", wcount, 0);

        for (int k = 0; k < 4; k++) begin
            tick(14'h2010, 1'b0, 1'b0);
            if (k == 3) cmp("call_q3", {stack_push_en, pc_load_en, pc_src}, 3'b110);
        end
        // A second branch sitting in the flush slot is discarded.
        for (int k = 0; k < 4; k++) begin
            tick(14'h2FFF, 1'b0, 1'b0);
            if (k == 3) cmp("b2b_discard", {pc_load_en, incr_pc_en}, 2'b01);
        end
        for (int k = 0; k < 4; k++) begin
            tick(14'h3477, 1'b0, 1'b0);
            if (k == 0) cmp("retlw_noflush", flush_active, 0);
            if (k == 1) cmp("retlw_q1", {w_reg_wr_en, alu_op}, {1'b1, OP_PASSLF});
            if (k == 3) cmp("retlw_q3", {stack_pop_en, pc_load_en, pc_src}, 3'b111);
        end
        for (int k = 0; k < 4; k++) begin
            tick(14'h0000, 1'b0, 1'b0);
            if (k == 0) cmp("retlw_flush", flush_active, 1);
        end

        wcount = 0;
        tick(14'h3955, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick(14'h3955, 1'b1, 1'b0);
            cmp("hold_q", q_count, 1);
        end
        cmp("hold_no_w", wcount, 0);
        tick(14'h3955, 1'b0, 1'b0);
        cmp("release_q1", {q_count, w_reg_wr_en, alu_op}, {2'd1, 1'b1, OP_AND});
        tick(14'h3955, 1'b0, 1'b0);
        tick(14'h3955, 1'b0, 1'b0);
        cmp("release_once", wcount, 1);

        for (int k = 0; k < 3; k++) tick(14'h2805, 1'b0, 1'b0);
        tick(14'h2805, 1'b1, 1'b0);
        cmp("hold_q3_noload", pc_load_en, 0);
        tick(14'h2805, 1'b1, 1'b0);
        tick(14'h2805, 1'b0, 1'b0);
        cmp("hold_q3_load", {q_count, pc_load_en}, {2'd3, 1'b1});
        tick(14'h0000, 1'b0, 1'b0);
        cmp("hold_q3_flush", flush_active, 1);
        for (int k = 0; k < 3; k++) tick(14'h0000, 1'b0, 1'b0);

        for (int k = 0; k < 4; k++) begin
            tick(14'h3F7F, 1'b0, 1'b0);
            if (k == 1) cmp("legal_3f7f", illegal_instr, 0);
        end
        wcount = 0;
        for (int k = 0; k < 4; k++) begin
            tick(14'h0001, 1'b0, 1'b0);
            if (k == 0) cmp("illegal_0001", illegal_instr, 1);
            if (k == 3) cmp("illegal_nop_q3", {incr_pc_en, pc_load_en}, 2'b10);
        end
        cmp("illegal_no_w", wcount, 0);

        tick(14'h2010, 1'b0, 1'b0);
        tick(14'h2010, 1'b0, 1'b0);
        tick(14'h2010, 1'b0, 1'b1);
        cmp("rst_mid_call", stack_push_en, 0);
        tick(14'h0000, 1'b0, 1'b0);
        cmp("rst_abort_q", {q_count, flush_active}, {2'd0, 1'b1});
        for (int k = 0; k < 3; k++) tick(14'h0000, 1'b0, 1'b0);
        nop_cycle();

        @(posedge clk);
        #1;
        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lit_branch_decoder.md
# lit_branch_decoder

Second-generation instruction decoder/sequencer for the PIC16F-style core. It counts the four Q phases of every instruction cycle and decodes the whole literal group plus the control-flow group: MOVLW, ADDLW, SUBLW, ANDLW, IORLW, XORLW, GOTO, CALL, RETURN, RETLW and NOP. It adds pipeline flush (forced-NOP cycle after every PC change), a hold input that freezes the sequencer, and an illegal-opcode flag. It sits between the instruction register and the ALU, W register, PC and hardware stack.

## Interface
- ALU_OP_WIDTH, 4, width of alu_op.
- RESET_FLUSH, 1, when 1 the first cycle after reset is a flush cycle; when 0 it decodes instr_current directly.
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-high.
- instr_current  in  14  instruction register contents.
- hold  in  1  freeze: Q counter and flush state held; all enables forced 0.
- q_count  out  2  current Q phase (0..3).
- alu_sel_l  out  1  ALU B operand = literal instr_current[7:0].
- alu_op  out  ALU_OP_WIDTH  ALU operation; named constants from the team ALU op header.
- alu_status_wr_en  out  1  write Z/C/DC from ALU.
- w_reg_wr_en  out  1  write ALU result to W.
- instr_rd_en  out  1  load instruction register from mem[PC].
- incr_pc_en  out  1  PC <= PC+1.
- pc_load_en  out  1  PC <= (pc_src ? stack top : instr_current[10:0]).
- pc_src  out  1  0 = literal target, 1 = stack.
- stack_push_en  out  1  push current PC.
- stack_pop_en  out  1  pop stack.
- flush_active  out  1  current cycle is a forced NOP.
- illegal_instr  out  1  instr_current matches no supported encoding; the instruction executes as NOP.

## Operation
- Encodings (x = don't care, k = literal): NOP 00_0000_0xx0_0000; RETURN 00_0000_0000_1000; MOVLW 11_00xx_kkkk_kkkk; RETLW 11_01xx_k; IORLW 11_1000_k; ANDLW 11_1001_k; XORLW 11_1010_k; SUBLW 11_110x_k; ADDLW 11_111x_k; CALL 10_0kkk_kkkk_kkkk; GOTO 10_1k...
- State: q_count (2 bits, wraps 3->0) and flush flag.
- Every non-held Q3, regardless of instruction: instr_rd_en=1. This fetches mem[PC], and the fetched word is the prefetched next instruction.
- Q3 PC update: incr_pc_en=1 unless the instruction is a branch. For a branch, pc_load_en=1 and incr_pc_en=0; these two are never both high.
- Literal ops at Q1: alu_sel_l=1 and w_reg_wr_en=1.
  - MOVLW/RETLW: alu_op_passlf, alu_status_wr_en=0.
  - ADDLW: alu_op_add. SUBLW: alu_op_sub (k - W). ANDLW: alu_op_and. IORLW: alu_op_ior. XORLW: alu_op_xor.
  - ADDLW, SUBLW, ANDLW, IORLW and XORLW also set alu_status_wr_en=1.
- GOTO at Q3: pc_load_en=1, pc_src=0.
- CALL at Q3: stack_push_en=1, pc_load_en=1, pc_src=0. The push captures the already-incremented PC (the return address).
- RETURN at Q3: stack_pop_en=1, pc_load_en=1, pc_src=1.
- RETLW: the Q1 W write as above, then Q3 behaves as RETURN.
- Flush: any Q3 with pc_load_en=1 sets the flush flag at the Q3->Q0 edge, because the word fetched that cycle is stale.
  - During a flush cycle instr_current is ignored: only the Q3 instr_rd_en/incr_pc_en fetch occurs. No W, status, stack or pc_load activity; illegal_instr=0.
  - Flag clears at the end of that cycle's Q3.
- hold=1: all enable outputs 0; q_count and flush flag are not updated; q_count output still shows the frozen phase. The held phase's actions fire once, when hold deasserts.

## Timing
- Reset: q_count=0 and flush flag=RESET_FLUSH. All enables 0 while rst=1. flush_active=RESET_FLUSH after reset.
- Outputs are combinational from q_count, the flush flag, instr_current and hold; there is no output register.
- Instruction cycle = 4 clocks.
  - NOP/literal ops/illegal: 1 cycle.
  - GOTO/CALL/RETURN/RETLW: 2 cycles (execute + flush).
- rst asserted mid-cycle or mid-flush aborts immediately; the next clock is Q0 in reset state.
- Back-to-back branches: the second branch sits in the flush slot and is discarded.
- A hold rising on Q3 of a branch delays both pc_load_en and the flag set until release.

## Test plan
- Reset then NOPs with RESET_FLUSH=1 → cycle 0 flush_active=1. instr_rd_en+incr_pc_en exactly once per 4 clocks, at q_count=3. No other enables.
- MOVLW 0x3055 then ADDLW 0x3E01 → Q1 of the first: alu_sel_l=1, alu_op=passlf, w_reg_wr_en=1, status_wr_en=0. Q1 of the second: alu_op=add, status_wr_en=1.
- GOTO 0x2805 → Q3: pc_load_en=1, pc_src=0, incr_pc_en=0. Next cycle flush_active=1; a MOVLW present in instr_current produces no w_reg_wr_en.
- CALL 0x2010, then RETLW 0x3477 at the target → CALL Q3: push+load. RETLW Q1: W write with passlf. RETLW Q3: pop+load with pc_src=1. Each followed by a flush cycle.
- hold=1 for 5 clocks starting at q_count=1 of an ANDLW → q_count stays 1 and enables stay 0. On release, Q1 enables fire exactly once.
- Instruction 0x3F7F-class valid vs 0x0001 (unsupported) → illegal_instr=1 for 0x0001 only; that instruction shows NOP behaviour. rst pulsed at Q2 of a CALL → no push, q_count=0 next clock.
